// File: rtl/memory_writeback_stage_pkg.sv
// Shared types and constants for the memory/writeback pipeline stage.
package memory_writeback_stage_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 3;

    // Access sequencer states: IDLE accepts a new access, WAIT counts out a multi-cycle one.
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } mem_state_e;

    // Control half of the MEM/WB bundle. Data fields depend on the per-instance DATA_W
    // parameter, so they live beside this struct in the stage.
    typedef struct packed {
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] write_register;
        logic                  mem_to_reg;
    } memwb_ctrl_t;

endpackage

// File: rtl/memory_writeback_stage_if.sv
// EX/MEM inputs and fetch/stall/register-file outputs of the memory/writeback stage.
interface memory_writeback_stage_if
    import memory_writeback_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) ();

    logic                  in_MemRead;
    logic                  in_MemWrite;
    logic                  in_Branch;
    logic                  in_MemtoReg;
    logic                  in_RegWrite;
    logic                  in_Zero;
    logic [DATA_W-1:0]     in_ALUResult;
    logic [DATA_W-1:0]     in_Write_Data;
    logic [DATA_W-1:0]     in_BranchTarget;
    logic [REG_ADDR_W-1:0] in_WriteRegister;

    logic                  O_PC_Src;
    logic [DATA_W-1:0]     O_BranchTarget;
    logic                  O_Stall;
    logic                  O_RegWrite;
    logic [REG_ADDR_W-1:0] O_WriteRegister;
    logic [DATA_W-1:0]     O_WB_Data;

    // Upstream pipeline side.
    modport master (
        output in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite, in_Zero,
        output in_ALUResult, in_Write_Data, in_BranchTarget, in_WriteRegister,
        input  O_PC_Src, O_BranchTarget, O_Stall, O_RegWrite, O_WriteRegister, O_WB_Data
    );

    // Stage side.
    modport slave (
        input  in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite, in_Zero,
        input  in_ALUResult, in_Write_Data, in_BranchTarget, in_WriteRegister,
        output O_PC_Src, O_BranchTarget, O_Stall, O_RegWrite, O_WriteRegister, O_WB_Data
    );

endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory: combinational read, write on the rising clock edge.
// Contents are deliberately not reset.
module data_memory #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_W-1:0]    i_wdata,
    output logic [DATA_W-1:0]    o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_BITS];

    // Commit a write at the edge closing the access.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read sees pre-write contents during a same-cycle write.
    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_writeback_stage.sv
// Memory access + MEM/WB register stage with a stall sequencer for multi-cycle memory.
module memory_writeback_stage
    import memory_writeback_stage_pkg::*;
#(
    parameter int unsigned DATA_W       = memory_writeback_stage_pkg::DATA_W,
    parameter int unsigned DM_ADDR_BITS = 8,
    parameter int unsigned MEM_LATENCY  = 1
) (
    input logic                     clk,
    input logic                     rst,
    memory_writeback_stage_if.slave bus
);

    localparam bit         MultiCycle = (MEM_LATENCY > 1);
    // Remaining stall cycles after the first one; the final cycle is cnt == 0.
    localparam logic [3:0] CntLoad    = MultiCycle ? 4'(MEM_LATENCY - 2) : 4'd0;

    mem_state_e            r_state;
    logic [3:0]            r_cnt;
    memwb_ctrl_t           r_ctrl;
    logic [DATA_W-1:0]     r_rdata;
    logic [DATA_W-1:0]     r_alu;

    logic                  w_access;
    logic                  w_stall;
    logic                  w_mem_we;
    logic [DM_ADDR_BITS-1:0] w_word;
    logic [DATA_W-1:0]     w_rdata;
    logic                  w_unused_alu_bits;

    assign w_access = bus.in_MemRead | bus.in_MemWrite;
    // Bit 0 is a byte select and upper bits wrap, so only [DM_ADDR_BITS:1] index the array.
    assign w_word            = bus.in_ALUResult[DM_ADDR_BITS:1];
    assign w_unused_alu_bits = ^bus.in_ALUResult;

    // Stall covers every cycle of an access except its last; reset drops it at once.
    always_comb begin
        w_stall = 1'b0;
        if (!rst) begin
            unique case (r_state)
                StIdle:  w_stall = MultiCycle && w_access;
                StWait:  w_stall = (r_cnt != 4'd0);
                default: w_stall = 1'b0;
            endcase
        end
    end

    // Writes only on the final (non-stall) cycle; reset in WAIT therefore aborts the store.
    assign w_mem_we = bus.in_MemWrite & ~w_stall & ~rst;

    data_memory #(
        .DATA_W    (DATA_W),
        .ADDR_BITS (DM_ADDR_BITS)
    ) u_data_memory (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_word),
        .i_wdata (bus.in_Write_Data),
        .o_rdata (w_rdata)
    );

    // Access sequencer: enter WAIT on a multi-cycle access, count down to the final cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (MultiCycle && w_access) begin
                        r_state <= StWait;
                        r_cnt   <= CntLoad;
                    end
                end
                StWait: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // MEM/WB register: capture on non-stall edges, insert a bubble while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl  <= '0;
            r_rdata <= '0;
            r_alu   <= '0;
        end else if (w_stall) begin
            r_ctrl  <= '0;
            r_rdata <= '0;
            r_alu   <= '0;
        end else begin
            r_ctrl.reg_write      <= bus.in_RegWrite;
            r_ctrl.write_register <= bus.in_WriteRegister;
            r_ctrl.mem_to_reg     <= bus.in_MemtoReg;
            r_rdata               <= w_rdata;
            r_alu                 <= bus.in_ALUResult;
        end
    end

    assign bus.O_Stall         = w_stall;
    // Branch is only resolved once the stage is not frozen.
    assign bus.O_PC_Src        = bus.in_Branch & bus.in_Zero & ~rst & ~w_stall;
    assign bus.O_BranchTarget  = bus.in_BranchTarget;
    assign bus.O_RegWrite      = r_ctrl.reg_write;
    assign bus.O_WriteRegister = r_ctrl.write_register;
    assign bus.O_WB_Data       = r_ctrl.mem_to_reg ? r_rdata : r_alu;

endmodule

// File: doc/memory_writeback_stage.md
MEMORY_WRITEBACK_STAGE -- requirements
Module: memory_writeback_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning datapath width.
REQ-002 The block SHALL have parameter DM_ADDR_BITS, default 8, meaning data memory holds 2^DM_ADDR_BITS words.
REQ-003 The block SHALL have parameter MEM_LATENCY, default 1, meaning cycles per data-memory access (1..15).
REQ-004 The block SHALL have these ports: clk  in  1  clock, rising edge.
REQ-005 The block SHALL have these ports: rst  in  1  reset, asynchronous and active-high.
REQ-006 The block SHALL have these ports: in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite, in_Zero  in  1 each  EX/MEM control.
REQ-007 The block SHALL have these ports: in_ALUResult, in_Write_Data, in_BranchTarget  in  DATA_W each  address/ALU value, store data, branch target.
REQ-008 The block SHALL have these ports: in_WriteRegister  in  3  destination register.
REQ-009 The block SHALL have these ports: O_PC_Src  out  1  take-branch select to fetch.
REQ-010 The block SHALL have these ports: O_BranchTarget  out  DATA_W  pass-through of in_BranchTarget.
REQ-011 The block SHALL have these ports: O_Stall  out  1  upstream freezes PC and IF/ID, ID/EX, EX/MEM.
REQ-012 The block SHALL have these ports: O_RegWrite  out  1, O_WriteRegister  out  3, O_WB_Data  out  DATA_W  register-file write port.

Function
REQ-013 O_PC_Src SHALL equal in_Branch AND in_Zero, combinational, forced 0 while rst or O_Stall.
REQ-014 Word index SHALL be in_ALUResult[DM_ADDR_BITS:1]; bit 0 ignored; higher bits ignored (wrap-around).
REQ-015 Data memory read SHALL be combinational from the array; writes SHALL commit on the rising edge of an access's final cycle.
REQ-016 In-cycle MemRead and MemWrite both high SHALL perform the write; captured read data is the pre-write contents.
REQ-017 FSM states: IDLE, WAIT; 4-bit down-counter cnt.
REQ-018 IDLE with (MemRead|MemWrite) and MEM_LATENCY>1: O_Stall=1, go WAIT, cnt=MEM_LATENCY-2.
REQ-019 WAIT with cnt>0: O_Stall=1, cnt decrements; WAIT with cnt=0: O_Stall=0 (final cycle), return IDLE.
REQ-020 MEM_LATENCY=1 SHALL never assert O_Stall; every access is single-cycle.
REQ-021 Inputs SHALL be held stable by upstream while O_Stall=1; the block does not re-sample them mid-access.
REQ-022 MEM/WB register SHALL load RegWrite, WriteRegister, MemtoReg, read data, ALUResult on every non-stall edge; on stall edges it SHALL load a bubble (RegWrite=0).
REQ-023 O_WB_Data SHALL be registered MemtoReg ? read data : ALUResult, combinational from MEM/WB contents.
REQ-024 Load-to-writeback latency SHALL be MEM_LATENCY cycles after the access first appears.
REQ-025 Store followed next cycle by load to same word SHALL return the stored value.

Reset
REQ-026 rst SHALL force FSM to IDLE, cnt=0, O_Stall=0, O_PC_Src=0, O_RegWrite=0, O_WriteRegister=0, O_WB_Data=0.
REQ-027 rst during WAIT SHALL abort the access; no write SHALL commit.
REQ-028 Data memory contents SHALL NOT be reset; simulation initial contents are zero.

Structure
REQ-029 Shared package SHALL hold DATA_W, REG_ADDR_W=3, FSM state encoding and the MEM/WB bundle typedef.
REQ-030 Data memory SHALL be a sub-module data_memory (comb read, sync write, array only); FSM and MEM/WB register stay in top.

Verification
REQ-031 Latency 1: store 0x1234 at addr 0x0010, then load with RegWrite, rd=3 -> O_WB_Data=0x1234, O_WriteRegister=3, O_RegWrite=1 one cycle after load.
REQ-032 Branch=1, Zero=1, target 0x0040 -> O_PC_Src=1, O_BranchTarget=0x0040 same cycle; Zero=0 -> O_PC_Src=0.
REQ-033 MEM_LATENCY=3, load -> O_Stall high 2 cycles, bubbles (O_RegWrite=0) meanwhile, data written back on third edge.
REQ-034 MEM_LATENCY=3, store 0xBEEF, rst asserted in WAIT -> O_Stall=0 immediately; later load of that word returns previous value.
REQ-035 Addr 0x0201 with DM_ADDR_BITS=8 -> aliases word 0x00; same-cycle read+write returns old data, next load returns new.
REQ-036 R-type (MemtoReg=0, ALUResult=0x00FF, rd=5) -> O_WB_Data=0x00FF, O_Stall never asserted.
